mem_responder: RTL and testbench

Memory-side responder for the datapath's MAR/MDR memory port. It accepts single-word read and write requests and models configurable wait states with a small FSM. It owns the word-addressed storage array and returns read data with a one-cycle `ready` completion pulse. It sits between the MAR/MDR registers and replaces the zero-latency RAM, so the control unit must wait on `ready` rather than assume a fixed memory cycle.

---
 rtl/mem_responder_if.sv | 17 +
 rtl/mem_responder.sv | 110 +++++++++++
 tb/tb_mem_responder.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Request/response bundle between the MAR/MDR datapath (master) and mem_responder (slave).
interface mem_responder_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;
  logic              busy;
  logic              err;

  modport master (output read, write, addr, wdata, input rdata, ready, busy, err);
  modport slave  (input read, write, addr, wdata, output rdata, ready, busy, err);
endinterface

// File: rtl/mem_responder.sv
// Wait-state memory responder owning the word array; one-cycle ready pulse per transaction.
// Optional MEM_RANGE_CHECK_EN: out-of-range addresses are not accessed and pulse err with ready.
module mem_responder #(
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 512,
  parameter int WAIT_CYCLES = 2
) (
  input logic            clk_i,
  input logic            rst_i,
  mem_responder_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wrOp_q, wrOp_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ready_q, busy_q;
  logic              inRange;
  logic [IDX_W-1:0]  idx;

  logic [DATA_W-1:0] mem [DEPTH];

  assign idx = addr_q[IDX_W-1:0];

`ifdef MEM_RANGE_CHECK_EN
  logic err_q;
  assign inRange = ({1'b0, addr_q} < (ADDR_W+1)'(DEPTH));
  assign bus.err = err_q;
`else
  assign inRange = 1'b1;
  assign bus.err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wrOp_d  = wrOp_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        // write takes priority when both requests are raised together
        if (bus.read || bus.write) begin
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          wrOp_d  = bus.write;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (!wrOp_q) rdata_d = inRange ? mem[idx] : '0;
        state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wrOp_q  <= 1'b0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wrOp_q  <= wrOp_d;
      rdata_q <= rdata_d;
      ready_q <= (state_d == S_DONE);
      busy_q  <= (state_d != S_IDLE);
    end
  end

`ifdef MEM_RANGE_CHECK_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) err_q <= 1'b0;
    else       err_q <= (state_q == S_ACCESS) && !inRange;
  end
`endif

  // Array is deliberately left out of reset; async reset clears state_q so no commit happens.
  always_ff @(posedge clk_i) begin
    if (state_q == S_ACCESS && wrOp_q && inRange) mem[idx] <= wdata_q;
  end

  assign bus.rdata = rdata_q;
  assign bus.ready = ready_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed testbench for mem_responder: three instances cover WAIT_CYCLES 2/0/1 and DEPTH 256.
module tb_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mem_responder_if #(.ADDR_W(9), .DATA_W(32)) busA ();
  mem_responder_if #(.ADDR_W(9), .DATA_W(32)) busB ();
  mem_responder_if #(.ADDR_W(9), .DATA_W(32)) busC ();

  mem_responder #(.ADDR_W(9), .DATA_W(32), .DEPTH(512), .WAIT_CYCLES(2))
    dutA (.clk_i(clk), .rst_i(rst), .bus(busA));
  mem_responder #(.ADDR_W(9), .DATA_W(32), .DEPTH(512), .WAIT_CYCLES(0))
    dutB (.clk_i(clk), .rst_i(rst), .bus(busB));
  mem_responder #(.ADDR_W(9), .DATA_W(32), .DEPTH(256), .WAIT_CYCLES(1))
    dutC (.clk_i(clk), .rst_i(rst), .bus(busC));

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic setReq(input int sel, input logic rd, input logic wr,
                        input logic [8:0] a, input logic [31:0] d);
    case (sel)
      0: begin busA.read = rd; busA.write = wr; busA.addr = a; busA.wdata = d; end
      1: begin busB.read = rd; busB.write = wr; busB.addr = a; busB.wdata = d; end
      default: begin busC.read = rd; busC.write = wr; busC.addr = a; busC.wdata = d; end
    endcase
  endtask

  function automatic logic getReady(input int sel);
    case (sel)
      0: return busA.ready;
      1: return busB.ready;
      default: return busC.ready;
    endcase
  endfunction

  function automatic logic getBusy(input int sel);
    case (sel)
      0: return busA.busy;
      1: return busB.busy;
      default: return busC.busy;
    endcase
  endfunction

  function automatic logic [31:0] getRdata(input int sel);
    case (sel)
      0: return busA.rdata;
      1: return busB.rdata;
      default: return busC.rdata;
    endcase
  endfunction

  function automatic logic getErr(input int sel);
    case (sel)
      0: return busA.err;
      1: return busB.err;
      default: return busC.err;
    endcase
  endfunction

  // Raise a request at a falling edge, drop it after acceptance, and count edges
  // (acceptance edge included) until ready is seen; edges = -1 on timeout.
  task automatic applyStimulus(input int sel, input logic rd, input logic wr,
                               input logic [8:0] a, input logic [31:0] d,
                               output int edges, output logic busyMid,
                               output logic [31:0] data, output logic errSeen,
                               output logic readyAfter);
    bit found;
    found = 1'b0;
    edges = 0;
    busyMid = 1'b0;
    data = '0;
    errSeen = 1'b0;
    @(negedge clk);
    setReq(sel, rd, wr, a, d);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      edges++;
      #1 setReq(sel, 1'b0, 1'b0, a, d);
      @(negedge clk);
      if (edges == 1) busyMid = getBusy(sel);
      if (getReady(sel)) begin
        data = getRdata(sel);
        errSeen = getErr(sel);
        found = 1'b1;
        break;
      end
    end
    if (!found) edges = -1;
    @(negedge clk);
    readyAfter = getReady(sel);
  endtask

  int          lat;
  logic        bsy, errS, rdyAfter;
  logic [31:0] dat;
  int          readyCount;

  initial begin
    setReq(0, 1'b0, 1'b0, '0, '0);
    setReq(1, 1'b0, 1'b0, '0, '0);
    setReq(2, 1'b0, 1'b0, '0, '0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_rdata", busA.rdata, 32'h0);
    checkOutput("rst_ready", {31'b0, busA.ready}, 32'h0);
    checkOutput("rst_busy",  {31'b0, busA.busy}, 32'h0);
    checkOutput("rst_err",   {31'b0, busC.err}, 32'h0);
    rst = 1'b0;

    readyCount = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busA.ready || busB.ready || busC.ready) readyCount++;
    end
    checkOutput("idle_no_ready", readyCount, 32'd0);

    $display("[TB] WAIT_CYCLES=2 write/read");
    applyStimulus(0, 1'b0, 1'b1, 9'h005, 32'hDEADBEEF, lat, bsy, dat, errS, rdyAfter);
    checkOutput("w2_wr_latency", lat, 32'd4);
    checkOutput("w2_wr_busy", {31'b0, bsy}, 32'd1);
    checkOutput("w2_wr_rdata_kept", dat, 32'h0);
    checkOutput("w2_wr_ready_pulse", {31'b0, rdyAfter}, 32'd0);
    checkOutput("w2_idle_busy", {31'b0, busA.busy}, 32'd0);
    applyStimulus(0, 1'b1, 1'b0, 9'h005, 32'h0, lat, bsy, dat, errS, rdyAfter);
    checkOutput("w2_rd_latency", lat, 32'd4);
    checkOutput("w2_rd_data", dat, 32'hDEADBEEF);
    checkOutput("w2_rd_hold", busA.rdata, 32'hDEADBEEF);

    $display("[TB] WAIT_CYCLES=0 write/read at top address");
    applyStimulus(1, 1'b0, 1'b1, 9'h1FF, 32'h00000123, lat, bsy, dat, errS, rdyAfter);
    checkOutput("w0_wr_latency", lat, 32'd2);
    applyStimulus(1, 1'b1, 1'b0, 9'h1FF, 32'h0, lat, bsy, dat, errS, rdyAfter);
    checkOutput("w0_rd_latency", lat, 32'd2);
    checkOutput("w0_rd_data", dat, 32'h00000123);
    checkOutput("w0_ready_pulse", {31'b0, rdyAfter}, 32'd0);

    $display("[TB] simultaneous read+write");
    applyStimulus(0, 1'b1, 1'b1, 9'h010, 32'hA5A5A5A5, lat, bsy, dat, errS, rdyAfter);
    checkOutput("rw_latency", lat, 32'd4);
    checkOutput("rw_rdata_unchanged", dat, 32'hDEADBEEF);
    applyStimulus(0, 1'b1, 1'b0, 9'h010, 32'h0, lat, bsy, dat, errS, rdyAfter);
    checkOutput("rw_readback", dat, 32'hA5A5A5A5);

    $display("[TB] reset during WAIT");
    applyStimulus(0, 1'b0, 1'b1, 9'h020, 32'h22222222, lat, bsy, dat, errS, rdyAfter);
    checkOutput("pre_wr_latency", lat, 32'd4);
    @(negedge clk);
    setReq(0, 1'b0, 1'b1, 9'h020, 32'h11111111);
    @(posedge clk);
    #1 setReq(0, 1'b0, 1'b0, 9'h020, 32'h0);
    @(negedge clk);
    checkOutput("abort_busy_before", {31'b0, busA.busy}, 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("abort_busy", {31'b0, busA.busy}, 32'd0);
    checkOutput("abort_rdata", busA.rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(0, 1'b1, 1'b0, 9'h020, 32'h0, lat, bsy, dat, errS, rdyAfter);
    checkOutput("abort_readback", dat, 32'h22222222);

    $display("[TB] DEPTH=256 range behaviour");
    applyStimulus(2, 1'b0, 1'b1, 9'h000, 32'h0BADF00D, lat, bsy, dat, errS, rdyAfter);
    checkOutput("d256_wr_latency", lat, 32'd3);
    checkOutput("d256_wr_err", {31'b0, errS}, 32'd0);
    applyStimulus(2, 1'b1, 1'b0, 9'h100, 32'h0, lat, bsy, dat, errS, rdyAfter);
    checkOutput("d256_rd_latency", lat, 32'd3);
`ifdef MEM_RANGE_CHECK_EN
    checkOutput("d256_oor_err", {31'b0, errS}, 32'd1);
    checkOutput("d256_oor_rdata", dat, 32'h0);
`else
    checkOutput("d256_wrap_err", {31'b0, errS}, 32'd0);
    checkOutput("d256_wrap_rdata", dat, 32'h0BADF00D);
`endif
    checkOutput("d256_err_pulse", {31'b0, busC.err}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
